// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction fetch front-end
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int         PC_W_MAX = 16;
  localparam logic [3:0] OPC_JUMP = 4'hA;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W_MAX-1:0] pc;
    logic [15:0]         inst;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo : synchronous FIFO of {pc, inst} entries with flush
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

  fetch_entry_t       store [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_16bit.sv
// ----------------------------------------------------------------------------
// inst_fetch_16bit : pc sequencer + fetch buffer feeding decode.
// Optional JUMP_PREDECODE_EN follows opcode-A jumps at fetch.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_fetch_16bit
  import fetch_pkg::*;
#(
  parameter int PC_W       = 16,
  parameter int LAST_ADDR  = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     inst,
  output logic [15:0]     dec_inst,
  output logic [PC_W-1:0] dec_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            halted
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(LAST_ADDR);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] seq_pc;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign dec_valid  = !empty;
  assign pop        = dec_valid && dec_ready;
  assign dec_inst   = head.inst;
  assign dec_pc     = head.pc[PC_W-1:0];
  assign halted     = (state == HALT);
  assign push_entry = '{pc: PC_W_MAX'(pc), inst: inst};

  always_comb begin
    seq_pc = pc + 1'b1;
`ifdef JUMP_PREDECODE_EN
    if (inst[15:12] == OPC_JUMP) begin
      seq_pc = {{(PC_W-12){1'b0}}, inst[11:0]};
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    if (br_taken) begin
      state_nxt = FETCH;
      pc_nxt    = br_target;
    end else begin
      case (state)
        FETCH: begin
          if (!full || pop) begin
            push = 1'b1;
            // Anything at or past the last address is fetched once, then we stop.
            if (pc >= LAST_PC) begin
              state_nxt = HALT;
            end else begin
              pc_nxt = seq_pc;
            end
          end
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (br_taken),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

endmodule

`default_nettype wire
